// File: rtl/csr_intr_unit.sv
// csr_intr_unit: machine-mode CSRs plus external interrupt
// synchroniser, edge detect and pending latch.
module csr_intr_unit #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        intr_ext,
  input  logic        intrpt_taken,
  input  logic        csr_we,
  input  logic        mret_exec,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic [31:0] pc,
  output logic [31:0] csr_rdata,
  output logic        intrpt_vld,
  output logic [31:0] mtvec_out,
  output logic [31:0] mepc_out,
  output logic        mie_bit
);

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [31:0] C_EXT_INT = 32'h8000_000B;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_arm;
  logic                   r_prev;
  logic                   r_pend;
  logic                   r_mie;
  logic                   r_mpie;
  logic [31:2]            r_mtvec;
  logic [31:0]            r_mepc;
  logic [31:0]            r_mcause;

  logic                   w_sync_out;
  logic                   w_edge;
  logic                   w_sel_mst;
  logic                   w_sel_tvec;
  logic                   w_sel_epc;
  logic                   w_sel_cause;
  logic                   w_mie_n;
  logic                   w_mpie_n;
  logic [31:2]            w_mtvec_n;
  logic [31:0]            w_mepc_n;
  logic [31:0]            w_mcause_n;

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  // r_arm stays low until the chain has shown a real low sample,
  // so a level held across reset release is not an edge.
  assign w_edge = w_sync_out & ~r_prev & r_arm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_fill <= '0;
      r_arm  <= 1'b0;
      r_prev <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], intr_ext};
      r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_arm  <= r_arm | (r_fill[SYNC_STAGES-1] & ~w_sync_out);
      r_prev <= w_sync_out;
      r_pend <= w_edge | (r_pend & ~intrpt_taken);
    end
  end

  assign w_sel_mst   = (csr_addr == A_MSTATUS);
  assign w_sel_tvec  = (csr_addr == A_MTVEC);
  assign w_sel_epc   = (csr_addr == A_MEPC);
  assign w_sel_cause = (csr_addr == A_MCAUSE);

  // Later assignments win: trap entry, then mret, override csr writes.
  always_comb begin
    w_mie_n    = r_mie;
    w_mpie_n   = r_mpie;
    w_mtvec_n  = r_mtvec;
    w_mepc_n   = r_mepc;
    w_mcause_n = r_mcause;
    if (csr_we) begin
      unique case (1'b1)
        w_sel_mst: begin
          w_mie_n  = csr_wdata[3];
          w_mpie_n = csr_wdata[7];
        end
        w_sel_tvec:  w_mtvec_n  = csr_wdata[31:2];
        w_sel_epc:   w_mepc_n   = csr_wdata;
        w_sel_cause: w_mcause_n = csr_wdata;
        default: ;
      endcase
    end
    if (intrpt_taken) begin
      w_mepc_n   = pc;
      w_mcause_n = C_EXT_INT;
      w_mpie_n   = r_mie;
      w_mie_n    = 1'b0;
    end else if (mret_exec) begin
      w_mie_n  = r_mpie;
      w_mpie_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mie    <= 1'b0;
      r_mpie   <= 1'b0;
      r_mtvec  <= MTVEC_RESET[31:2];
      r_mepc   <= '0;
      r_mcause <= '0;
    end else begin
      r_mie    <= w_mie_n;
      r_mpie   <= w_mpie_n;
      r_mtvec  <= w_mtvec_n;
      r_mepc   <= w_mepc_n;
      r_mcause <= w_mcause_n;
    end
  end

  always_comb begin
    csr_rdata = '0;
    unique case (1'b1)
      w_sel_mst:   csr_rdata = {24'h0, r_mpie, 3'b000, r_mie, 3'b000};
      w_sel_tvec:  csr_rdata = {r_mtvec, 2'b00};
      w_sel_epc:   csr_rdata = r_mepc;
      w_sel_cause: csr_rdata = r_mcause;
      default: ;
    endcase
  end

  assign intrpt_vld = r_pend & r_mie;
  assign mtvec_out  = {r_mtvec, 2'b00};
  assign mepc_out   = r_mepc;
  assign mie_bit    = r_mie;

endmodule

// File: tb/tb_csr_intr_unit.sv
// tb_csr_intr_unit: directed scoreboard bench for csr_intr_unit.
// Expectations are queued with stimulus and drained after each step.
module tb_csr_intr_unit;

  logic        clk;
  logic        rst_n;
  logic        intr_ext;
  logic        intrpt_taken;
  logic        csr_we;
  logic        mret_exec;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] pc;
  logic [31:0] csr_rdata;
  logic        intrpt_vld;
  logic [31:0] mtvec_out;
  logic [31:0] mepc_out;
  logic        mie_bit;

  int total = 0;
  int bad   = 0;

  typedef enum logic [2:0] {S_RD, S_VLD, S_TVEC, S_EPC, S_MIE} sel_e;
  typedef struct {
    string       tag;
    sel_e        sel;
    logic [11:0] addr;
    logic [31:0] val;
  } exp_t;

  exp_t sbq[$];

  csr_intr_unit #(
    .SYNC_STAGES(2),
    .MTVEC_RESET(32'h0000_1003)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .intr_ext(intr_ext),
    .intrpt_taken(intrpt_taken),
    .csr_we(csr_we),
    .mret_exec(mret_exec),
    .csr_addr(csr_addr),
    .csr_wdata(csr_wdata),
    .pc(pc),
    .csr_rdata(csr_rdata),
    .intrpt_vld(intrpt_vld),
    .mtvec_out(mtvec_out),
    .mepc_out(mepc_out),
    .mie_bit(mie_bit)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic want(input string tag, input sel_e sel,
                      input logic [11:0] addr, input logic [31:0] val);
    exp_t e;
    e.tag  = tag;
    e.sel  = sel;
    e.addr = addr;
    e.val  = val;
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.sel == S_RD) begin
        csr_addr = e.addr;
        #1;
      end
      case (e.sel)
        S_RD:    obs = csr_rdata;
        S_VLD:   obs = {31'h0, intrpt_vld};
        S_TVEC:  obs = mtvec_out;
        S_EPC:   obs = mepc_out;
        default: obs = {31'h0, mie_bit};
      endcase
      total++;
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    csr_we    = 1'b1;
    csr_addr  = a;
    csr_wdata = d;
    tick(1);
    csr_we    = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    intr_ext     = 1'b0;
    intrpt_taken = 1'b0;
    csr_we       = 1'b0;
    mret_exec    = 1'b0;
    csr_addr     = 12'h300;
    csr_wdata    = '0;
    pc           = '0;
    tick(2);
    rst_n = 1'b1;

    want("rst_vld", S_VLD, 12'h0, 32'h0);
    want("rst_mtvec", S_TVEC, 12'h0, 32'h0000_1000);
    want("rst_mepc", S_EPC, 12'h0, 32'h0);
    want("rst_mie", S_MIE, 12'h0, 32'h0);
    want("rst_mstatus", S_RD, 12'h300, 32'h0);
    drain();

    csr_we    = 1'b1;
    csr_addr  = 12'h305;
    csr_wdata = 32'h0000_0107;
    want("mtvec_old_rd", S_RD, 12'h305, 32'h0000_1000);
    drain();
    tick(1);
    csr_we = 1'b0;
    want("mtvec_out", S_TVEC, 12'h0, 32'h0000_0104);
    want("mtvec_rd", S_RD, 12'h305, 32'h0000_0104);
    drain();

    csr_wr(12'h300, 32'hFFFF_FFFF);
    want("mstatus_ff", S_RD, 12'h300, 32'h0000_0088);
    want("mie_set", S_MIE, 12'h0, 32'h1);
    drain();
    csr_wr(12'h341, 32'h0000_55AA);
    want("mepc_wr", S_EPC, 12'h0, 32'h0000_55AA);
    csr_wr(12'h342, 32'h0000_1234);
    want("mcause_wr", S_RD, 12'h342, 32'h0000_1234);
    csr_wr(12'h7C0, 32'hDEAD_BEEF);
    want("unmapped_rd", S_RD, 12'h7C0, 32'h0);
    drain();

    #3 rst_n = 1'b0;
    #1;
    want("arst_mepc", S_EPC, 12'h0, 32'h0);
    want("arst_mie", S_MIE, 12'h0, 32'h0);
    want("arst_mtvec", S_TVEC, 12'h0, 32'h0000_1000);
    want("arst_mstatus", S_RD, 12'h300, 32'h0);
    drain();
    @(negedge clk);
    tick(1);
    rst_n = 1'b1;

    csr_wr(12'h300, 32'h0000_0008);
    intr_ext = 1'b1;
    tick(1);
    want("lat_e1", S_VLD, 12'h0, 32'h0);
    drain();
    tick(1);
    want("lat_e2", S_VLD, 12'h0, 32'h0);
    drain();
    tick(1);
    want("lat_e3", S_VLD, 12'h0, 32'h1);
    drain();

    intrpt_taken = 1'b1;
    pc = 32'h0000_0040;
    tick(1);
    intrpt_taken = 1'b0;
    want("ent_mepc", S_EPC, 12'h0, 32'h0000_0040);
    want("ent_mcause", S_RD, 12'h342, 32'h8000_000B);
    want("ent_mstatus", S_RD, 12'h300, 32'h0000_0080);
    want("ent_vld", S_VLD, 12'h0, 32'h0);
    drain();

    mret_exec = 1'b1;
    tick(1);
    mret_exec = 1'b0;
    want("mret_mstatus", S_RD, 12'h300, 32'h0000_0088);
    want("mret_vld", S_VLD, 12'h0, 32'h0);
    drain();

    mret_exec = 1'b1;
    csr_wr(12'h300, 32'h0);
    mret_exec = 1'b0;
    want("mret_wr_drop", S_RD, 12'h300, 32'h0000_0088);
    drain();

    csr_wr(12'h300, 32'h0);
    intr_ext = 1'b0;
    tick(3);
    intr_ext = 1'b1;
    tick(4);
    want("mask_vld", S_VLD, 12'h0, 32'h0);
    drain();
    csr_we    = 1'b1;
    csr_addr  = 12'h300;
    csr_wdata = 32'h0000_0008;
    want("unmask_pre", S_VLD, 12'h0, 32'h0);
    drain();
    tick(1);
    csr_we = 1'b0;
    want("unmask_vld", S_VLD, 12'h0, 32'h1);
    drain();

    intr_ext = 1'b0;
    tick(3);
    intr_ext = 1'b1;
    tick(2);
    intrpt_taken = 1'b1;
    pc = 32'h0000_0080;
    tick(1);
    intrpt_taken = 1'b0;
    want("col_vld", S_VLD, 12'h0, 32'h0);
    want("col_mepc", S_EPC, 12'h0, 32'h0000_0080);
    drain();
    mret_exec = 1'b1;
    tick(1);
    mret_exec = 1'b0;
    want("col_reassert", S_VLD, 12'h0, 32'h1);
    drain();
    intrpt_taken = 1'b1;
    tick(1);
    intrpt_taken = 1'b0;
    mret_exec = 1'b1;
    tick(1);
    mret_exec = 1'b0;
    want("col_cleared", S_VLD, 12'h0, 32'h0);
    drain();

    #3 rst_n = 1'b0;
    #1;
    want("arst2_vld", S_VLD, 12'h0, 32'h0);
    drain();
    @(negedge clk);
    tick(1);
    rst_n = 1'b1;
    csr_wr(12'h300, 32'h0000_0008);
    tick(5);
    want("held_no_edge", S_VLD, 12'h0, 32'h0);
    want("held_mie", S_MIE, 12'h0, 32'h1);
    drain();
    intr_ext = 1'b0;
    tick(3);
    intr_ext = 1'b1;
    tick(2);
    want("rearm_e2", S_VLD, 12'h0, 32'h0);
    drain();
    tick(1);
    want("rearm_e3", S_VLD, 12'h0, 32'h1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csr_intr_unit.md
Name: csr_intr_unit

Overview:
- Machine-mode CSR file and interrupt controller for the multicycle core.
- Directly upstream of the control FSM: synchronises and latches the external interrupt and drives intrpt_vld into the FSM.
- Directly downstream of the FSM: consumes intrpt_taken, csr_we and the mret indication, and updates mstatus, mepc and mcause.
- Supplies mtvec_out and mepc_out to the PC source mux, and csr_rdata to the register-file write mux.

Parameters:
- SYNC_STAGES, 2, number of flops in the intr_ext synchroniser; legal range 2..4.
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec; bits [1:0] are ignored.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- intr_ext  in  1  external interrupt request; asynchronous, level, treated as rising-edge event.
- intrpt_taken  in  1  FSM is in interrupt state this cycle.
- csr_we  in  1  csrrw executing this cycle; write csr_wdata to csr_addr.
- mret_exec  in  1  mret executing this cycle (pulse).
- csr_addr  in  12  CSR address (instr[31:20]).
- csr_wdata  in  32  rs1 value.
- pc  in  32  PC of the instruction following the interrupted one.
- csr_rdata  out  32  combinational read of csr_addr.
- intrpt_vld  out  1  interrupt pending and enabled.
- mtvec_out  out  32  trap vector; bits [1:0] always 0.
- mepc_out  out  32  return address.
- mie_bit  out  1  mstatus.MIE, for debug/LED.

Behaviour:
- Reset (async assert, sync release to clk):
  - mstatus = 0 (MIE=0, MPIE=0).
  - mtvec = MTVEC_RESET with [1:0] forced to 0.
  - mepc = 0, mcause = 0.
  - Synchroniser flops, edge-history flop and pending = 0.
  - All outputs therefore 0, except mtvec_out = MTVEC_RESET & ~3.
- Synchroniser: intr_ext passes through a SYNC_STAGES flop chain. Rising-edge detect is sync_out & ~prev, with prev registered.
- Pending:
  - A detected edge sets pending.
  - intrpt_taken clears pending.
  - If an edge and intrpt_taken occur in the same cycle, pending stays 1 (the new event is not lost).
  - Multiple edges while pending coalesce into one event.
- intrpt_vld = pending & mstatus.MIE. This is combinational from registers only, with no input-to-output path. The FSM samples it in its execute/write-back state.
- Latency: intr_ext high to intrpt_vld high is SYNC_STAGES+1 rising edges when MIE=1.
- CSR map (all others read 0, writes ignored):
  - 0x300 mstatus: only bit 3 (MIE) and bit 7 (MPIE) are writable; other bits read 0.
  - 0x305 mtvec: bits [1:0] write-ignored, read 0.
  - 0x341 mepc: full 32 bits.
  - 0x342 mcause: read-write.
- csr_rdata returns the old value during the write cycle (csrrw semantics).
- Per-cycle update priority:
  1. intrpt_taken: mepc <= pc; mcause <= 32'h8000_000B; MPIE <= MIE; MIE <= 0.
  2. Else mret_exec: MIE <= MPIE; MPIE <= 1.
  3. csr_we: applies to any CSR not updated by rule 1 or 2 this cycle. A write to mstatus collides with rule 1 or 2, so the write is dropped.
- MIE=0 masks the interrupt but leaves pending set. intrpt_vld rises the cycle after MIE becomes 1.
- Reset mid-operation: all state clears immediately, including pending. An intr_ext level held through reset release is not an edge until it falls and rises again.

Test Plan:
- Reset: assert rst_n=0 mid-cycle → all outputs 0 asynchronously; mtvec_out=MTVEC_RESET&~3; csr_rdata at 0x300 = 0.
- CSR writes:
  - csr_we, addr 0x305, wdata 32'h0000_0107 → next cycle mtvec_out=32'h0000_0104, and csr_rdata during the write cycle = old value.
  - addr 0x300, wdata 32'hFFFF_FFFF → reads 32'h0000_0088.
- Interrupt entry: MIE=1, intr_ext 0→1 → intrpt_vld high exactly 3 edges later (SYNC_STAGES=2); pulse intrpt_taken with pc=32'h0000_0040 → mepc=32'h40, mcause=32'h8000_000B, MIE=0, MPIE=1, intrpt_vld=0.
- Masking: MIE=0, edge on intr_ext → intrpt_vld stays 0 and pending stays set; write mstatus=32'h8 → intrpt_vld=1 the next cycle.
- mret: after entry, pulse mret_exec → MIE=1, MPIE=1. Same-cycle mret_exec with csr_we to 0x300 (wdata 0) → MIE=1, write dropped.
- Collision: edge detected in the same cycle as intrpt_taken → pending remains 1; intrpt_vld reasserts after MIE is restored by mret.
